mul_stream_checker: RTL and testbench
=====================================

Name: mul_stream_checker

Overview:
- Receiving end of the sequential multiplier-stream FSM.
- The producer loads operand a and count b. It then emits one 2N-bit word {a, count} per valid cycle, counting b, b-1, …, 1, and afterwards raises a level "finished" flag.
- This block consumes that stream and checks framing and content. It rebuilds a*b by repeated addition and reports the product, the word count and a sticky error.

Parameters:
- N, 8, operand width; stream word width is 2N.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-high reset
- data_in  input  2N  stream word; [2N-1:N] = a, [N-1:0] = count
- data_valid  input  1  data_in is valid this cycle; no backpressure
- done_in  input  1  producer "finished" level; only its rising edge is used
- product  output  2N  last completed product a*b, held until the next completion
- product_valid  output  1  one-cycle pulse when product updates
- word_count  output  N  words accepted in the last completed frame
- busy  output  1  high in RECV or FIN
- error  output  1  sticky protocol-error flag, cleared only by rst

Behaviour:
- Reset (synchronous, rst=1 at clk edge):
  - product=0, product_valid=0, word_count=0, busy=0, error=0, state=IDLE.
  - Internal registers cleared: a_reg, acc, expected, cnt.
  - done_q (done_in delay register) is set to 1, so a done_in already high at reset release gives no edge.
- done_rise = done_in & ~done_q; done_q <= done_in every cycle.
- States: IDLE, RECV, FIN, ERR. All decisions are registered, so outputs change the cycle after the sampling edge.
- IDLE:
  - data_valid, count==0: go to ERR, error<=1.
  - data_valid, count!=0:
    - a_reg<=a, acc<=zero-extended a, cnt<=1, expected<=count-1.
    - Next state is FIN if count==1, else RECV.
  - done_rise with no data_valid (empty frame): product<=0, word_count<=0, product_valid pulse; stay in IDLE.
- RECV:
  - data_valid, upper!=a_reg or lower!=expected: go to ERR, error<=1.
  - data_valid, match: acc<=acc+a_reg, cnt<=cnt+1, expected<=expected-1.
    - Next state is FIN if lower==1, else RECV.
  - done_rise without data_valid (truncated frame): go to ERR.
  - data_valid and done_rise in the same cycle:
    - The word is processed first.
    - If that word is the final one (lower==1), the done edge completes the frame directly: product_valid pulses next cycle and state goes to IDLE.
    - Otherwise go to ERR.
- FIN:
  - done_rise: product<=acc, word_count<=cnt, product_valid pulse, go to IDLE.
  - data_valid (overrun): go to ERR.
  - Waits indefinitely otherwise.
- ERR:
  - Ignores data.
  - On done_rise returns to IDLE without a product_valid pulse.
  - error remains 1 until rst.
- Arithmetic:
  - acc is 2N bits; the maximum (2^N-1)^2 fits, so no overflow or wrap is possible.
  - cnt and expected are N bits; expected never decrements below 0 on a legal stream.
- busy=1 in RECV and FIN, 0 in IDLE and ERR.
- Reset mid-frame aborts the frame; no product_valid is generated for it.

Test Plan (N=8):
1. Normal frame:
   - Stimulus: 0x0503, 0x0502, 0x0501 on consecutive cycles, then done_in rises.
   - Required: product=0x000F, word_count=3, product_valid high exactly one cycle, busy back to 0, error=0.
2. Maximum frame:
   - Stimulus: a=0xFF, b=0xFF, 255 words 0xFFFF down to 0xFF01, with idle gaps between words, then done rise.
   - Required: product=0xFE01, word_count=255.
3. Content mismatch:
   - Stimulus: 0x0703, 0x0702, 0x0601.
   - Required: error=1 the cycle after the third word and no product_valid.
   - Stimulus: done rise, then frame 0x0201 plus done rise.
   - Required: ERR returns to IDLE; the new frame gives product=2 with error still 1.
4. Empty frame:
   - Stimulus: done_in rises in IDLE with no words.
   - Required: product=0, word_count=0, product_valid one-cycle pulse, error=0.
5. Truncation and overrun:
   - Stimulus: 0x0403, 0x0402, then done rise. Required: error=1.
   - Stimulus, after rst: 0x0301, then 0x0301 again before done. Required: error=1.
6. Reset mid-frame:
   - Stimulus: 0x0904 accepted, then rst held 2 cycles while done_in stays high.
   - Required: all outputs 0 and no spurious product_valid after release.
   - Stimulus: done_in low, then 0x0201, then done rise. Required: product=2.

Source files
------------

// File: rtl/mul_stream_checker.sv
// Receiver and checker for the sequential multiplier stream.
// It rebuilds a*b from the {a, count} words and flags framing or content errors.
module mul_stream_checker #(
    parameter int unsigned N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [2*N-1:0] data_in,
    input  logic           data_valid,
    input  logic           done_in,
    output logic [2*N-1:0] product,
    output logic           product_valid,
    output logic [N-1:0]   word_count,
    output logic           busy,
    output logic           error
);

    typedef enum logic [1:0] {StIdle, StRecv, StFin, StErr} state_e;

    localparam logic [N-1:0] OneN = {{(N-1){1'b0}}, 1'b1};

    state_e         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   exp_q, exp_d;
    logic [N-1:0]   cnt_q, cnt_d;
    logic [N-1:0]   wcount_q, wcount_d;
    logic [2*N-1:0] acc_q, acc_d;
    logic [2*N-1:0] prod_q, prod_d;
    logic           pvalid_q, pvalid_d;
    logic           error_q, error_d;
    logic           done_q;

    logic [N-1:0]   upper, lower;
    logic [2*N-1:0] acc_sum;
    logic           done_rise;

    assign upper     = data_in[2*N-1:N];
    assign lower     = data_in[N-1:0];
    assign done_rise = done_in & ~done_q;
    assign acc_sum   = acc_q + {{N{1'b0}}, a_q};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        exp_d    = exp_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        prod_d   = prod_q;
        wcount_d = wcount_q;
        pvalid_d = 1'b0;
        error_d  = error_q;
        unique case (state_q)
            StIdle: begin
                if (data_valid) begin
                    if (lower == '0) begin
                        state_d = StErr;
                        error_d = 1'b1;
                    end else begin
                        a_d   = upper;
                        acc_d = {{N{1'b0}}, upper};
                        cnt_d = OneN;
                        exp_d = lower - OneN;
                        if (lower == OneN) begin
                            // Single-word frame closed by a done edge in the same cycle.
                            if (done_rise) begin
                                prod_d   = {{N{1'b0}}, upper};
                                wcount_d = OneN;
                                pvalid_d = 1'b1;
                            end else begin
                                state_d = StFin;
                            end
                        end else if (done_rise) begin
                            state_d = StErr;
                            error_d = 1'b1;
                        end else begin
                            state_d = StRecv;
                        end
                    end
                end else if (done_rise) begin
                    prod_d   = '0;
                    wcount_d = '0;
                    pvalid_d = 1'b1;
                end
            end
            StRecv: begin
                if (data_valid) begin
                    if (upper != a_q || lower != exp_q) begin
                        state_d = StErr;
                        error_d = 1'b1;
                    end else begin
                        acc_d = acc_sum;
                        cnt_d = cnt_q + OneN;
                        exp_d = exp_q - OneN;
                        if (lower == OneN) begin
                            if (done_rise) begin
                                prod_d   = acc_sum;
                                wcount_d = cnt_q + OneN;
                                pvalid_d = 1'b1;
                                state_d  = StIdle;
                            end else begin
                                state_d = StFin;
                            end
                        end else if (done_rise) begin
                            state_d = StErr;
                            error_d = 1'b1;
                        end
                    end
                end else if (done_rise) begin
                    state_d = StErr;
                    error_d = 1'b1;
                end
            end
            StFin: begin
                if (data_valid) begin
                    state_d = StErr;
                    error_d = 1'b1;
                end else if (done_rise) begin
                    prod_d   = acc_q;
                    wcount_d = cnt_q;
                    pvalid_d = 1'b1;
                    state_d  = StIdle;
                end
            end
            StErr: begin
                if (done_rise) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            exp_q    <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            prod_q   <= '0;
            wcount_q <= '0;
            pvalid_q <= 1'b0;
            error_q  <= 1'b0;
            // A done level already high at reset release must not look like an edge.
            done_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            exp_q    <= exp_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            prod_q   <= prod_d;
            wcount_q <= wcount_d;
            pvalid_q <= pvalid_d;
            error_q  <= error_d;
            done_q   <= done_in;
        end
    end

    assign product       = prod_q;
    assign product_valid = pvalid_q;
    assign word_count    = wcount_q;
    assign busy          = (state_q == StRecv) || (state_q == StFin);
    assign error         = error_q;

endmodule

// File: tb/tb_mul_stream_checker.sv
// Directed bench for mul_stream_checker with a frame-level reference model
// compared against the outputs every cycle.
module tb_mul_stream_checker;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [2*N-1:0] data_in = '0;
    logic           data_valid = 1'b0;
    logic           done_in = 1'b0;
    logic [2*N-1:0] product;
    logic           product_valid;
    logic [N-1:0]   word_count;
    logic           busy;
    logic           error;

    int checks = 0;
    int passed = 0;

    mul_stream_checker #(.N(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .done_in      (done_in),
        .product      (product),
        .product_valid(product_valid),
        .word_count   (word_count),
        .busy         (busy),
        .error        (error)
    );

    always #5 clk = ~clk;

    // Frame-level model: a frame is open while words arrive; its product is a * words.
    bit started = 0;
    bit m_open, m_err_wait, m_done_prev;
    int m_a, m_next, m_words;
    logic [2*N-1:0] e_prod;
    logic [N-1:0]   e_wc;
    bit e_pv, e_err;

    task automatic m_fail_frame();
        e_err = 1; m_err_wait = 1; m_open = 0;
    endtask

    task automatic m_complete();
        int p;
        p = m_a * m_words;
        e_prod = p[2*N-1:0];
        e_wc = m_words[N-1:0];
        e_pv = 1; m_open = 0;
    endtask

    always @(posedge clk) begin
        bit rise, failed;
        int up, lo;
        started = 1;
        if (rst) begin
            m_open = 0; m_err_wait = 0; m_done_prev = 1;
            m_a = 0; m_next = 0; m_words = 0;
            e_prod = '0; e_wc = '0; e_pv = 0; e_err = 0;
        end else begin
            rise = done_in && !m_done_prev;
            m_done_prev = done_in;
            e_pv = 0;
            up = int'(data_in[2*N-1:N]);
            lo = int'(data_in[N-1:0]);
            failed = 0;
            if (m_err_wait) begin
                if (rise) m_err_wait = 0;
            end else if (data_valid) begin
                if (!m_open) begin
                    if (lo == 0) begin m_fail_frame(); failed = 1; end
                    else begin m_open = 1; m_a = up; m_words = 1; m_next = lo - 1; end
                end else if (m_next == 0 || up != m_a || lo != m_next) begin
                    m_fail_frame(); failed = 1;
                end else begin
                    m_words++; m_next--;
                end
                if (!failed && rise) begin
                    if (m_next == 0) m_complete(); else m_fail_frame();
                end
            end else if (rise) begin
                if (!m_open) begin
                    m_a = 0; m_words = 0; m_complete();
                end else if (m_next == 0) m_complete();
                else m_fail_frame();
            end
        end
    end

    always @(negedge clk) begin
        logic [2*N+N+2:0] act, exp;
        if (started) begin
            act = {product, product_valid, word_count, busy, error};
            exp = {e_prod, e_pv, e_wc, m_open, e_err};
            checks++;
            if (act === exp) passed++;
            else $display("FAIL model t=%0t: got prod=%h pv=%b wc=%0d busy=%b err=%b, want prod=%h pv=%b wc=%0d busy=%b err=%b",
                          $time, product, product_valid, word_count, busy, error,
                          e_prod, e_pv, e_wc, m_open, e_err);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Drive one cycle of inputs, then land on the negedge after they were sampled.
    task automatic step(input bit v, input logic [2*N-1:0] w, input bit d);
        data_valid = v; data_in = w; done_in = d;
        @(negedge clk);
    endtask

    task automatic do_reset(input bit d);
        rst = 1;
        step(0, '0, d); step(0, '0, d);
        rst = 0;
    endtask

    initial begin
        @(negedge clk);
        do_reset(0);
        chk("reset outputs", int'({product, product_valid, word_count, busy, error}), 0);

        // Normal frame 5*3.
        step(1, 16'h0503, 0);
        chk("t1 busy", int'(busy), 1);
        step(1, 16'h0502, 0);
        step(1, 16'h0501, 0);
        step(0, '0, 1);
        chk("t1 product", int'(product), 16'h000F);
        chk("t1 word_count", int'(word_count), 3);
        chk("t1 pv", int'(product_valid), 1);
        chk("t1 busy idle", int'(busy), 0);
        step(0, '0, 1);
        chk("t1 pv one cycle", int'(product_valid), 0);
        chk("t1 error", int'(error), 0);

        // Empty frame.
        step(0, '0, 0);
        step(0, '0, 1);
        chk("t4 product", int'(product), 0);
        chk("t4 word_count", int'(word_count), 0);
        chk("t4 pv", int'(product_valid), 1);
        chk("t4 error", int'(error), 0);
        step(0, '0, 0);
        chk("t4 pv one cycle", int'(product_valid), 0);

        // Maximum frame with gaps.
        for (int c = 255; c >= 1; c--) begin
            step(1, {8'hFF, 8'(c)}, 0);
            step(0, '0, 0);
        end
        step(0, '0, 1);
        chk("t2 product", int'(product), 16'hFE01);
        chk("t2 word_count", int'(word_count), 255);
        chk("t2 pv", int'(product_valid), 1);

        // Content mismatch then recovery.
        step(0, '0, 0);
        step(1, 16'h0703, 0);
        step(1, 16'h0702, 0);
        step(1, 16'h0601, 0);
        chk("t3 error", int'(error), 1);
        chk("t3 no pv", int'(product_valid), 0);
        step(0, '0, 1);
        chk("t3 busy after done", int'(busy), 0);
        step(0, '0, 0);
        step(1, 16'h0201, 0);
        step(0, '0, 1);
        chk("t3 product", int'(product), 2);
        chk("t3 pv", int'(product_valid), 1);
        chk("t3 error sticky", int'(error), 1);

        // Truncation.
        do_reset(0);
        chk("t5 reset error", int'(error), 0);
        step(1, 16'h0403, 0);
        step(1, 16'h0402, 0);
        step(0, '0, 1);
        chk("t5 truncation error", int'(error), 1);
        chk("t5 truncation no pv", int'(product_valid), 0);

        // Overrun.
        do_reset(0);
        step(1, 16'h0301, 0);
        step(1, 16'h0301, 0);
        chk("t5 overrun error", int'(error), 1);

        // Reset mid-frame with done held high across release.
        do_reset(0);
        step(1, 16'h0904, 0);
        chk("t6 busy", int'(busy), 1);
        do_reset(1);
        step(0, '0, 1);
        chk("t6 outputs zero", int'({product, product_valid, word_count, busy, error}), 0);
        step(0, '0, 1);
        chk("t6 no pv", int'(product_valid), 0);
        step(0, '0, 0);
        step(1, 16'h0201, 0);
        step(0, '0, 1);
        chk("t6 product", int'(product), 2);
        chk("t6 pv", int'(product_valid), 1);
        step(0, '0, 0);
        step(0, '0, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
